alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Shares the single combinational `alu` (SrcA, SrcB, ALUControl[1:0] -> ALUResult, ALUFlags[3:0]) between two requesters, e.g. a main datapath and an address-generation/co-processor port.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- A 3-state FSM sequences accept, execute and respond.
- Arbitration is round-robin.
- The ALU is instantiated outside this block and wired through the alu_* ports.

Parameters:
WIDTH, 32, operand/result width; must match the alu instance.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low: reset==0 at a rising clk edge resets all state
req_valid  input  2  bit i: requester i presents an operation
req_ready  output  2  bit i: op from requester i accepted this cycle
req0_srca  input  WIDTH  requester 0 operand A
req0_srcb  input  WIDTH  requester 0 operand B
req0_ctrl  input  2  requester 0 ALUControl
req1_srca  input  WIDTH  requester 1 operand A
req1_srcb  input  WIDTH  requester 1 operand B
req1_ctrl  input  2  requester 1 ALUControl
resp_valid  output  2  bit i: result for requester i available
resp_ready  input  2  bit i: requester i consumes result
resp_result  output  WIDTH  shared result bus; meaningful only while a resp_valid bit is high
resp_flags  output  4  shared {N,Z,C,V}
alu_srca  output  WIDTH  to alu SrcA
alu_srcb  output  WIDTH  to alu SrcB
alu_ctrl  output  2  to alu ALUControl
alu_result  input  WIDTH  from alu ALUResult
alu_flags  input  4  from alu ALUFlags

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset:
  - state=IDLE.
  - Registered operands (opa, opb, opc) = 0.
  - Result and flag registers = 0.
  - gnt = 0; last = 1, so requester 0 wins first.
  - req_ready=00, resp_valid=00, resp_result=0, resp_flags=0.
- IDLE:
  - Arbiter picks g. If only one req_valid bit is set, g is that requester. If both are set, g = ~last.
  - req_ready[g] = 1 combinationally, only in IDLE and only when req_valid[g]=1. The other bit is 0.
  - On the handshake (req_valid[g] & req_ready[g]): latch that requester's srca/srcb/ctrl into opa/opb/opc, set gnt=g, go to EXEC.
  - With no valid requests, remain in IDLE.
- EXEC:
  - alu_srca/alu_srcb/alu_ctrl are driven from opa/opb/opc in all states.
  - Capture alu_result and alu_flags into the result registers.
  - Go to RESP unconditionally.
- RESP:
  - resp_valid[gnt]=1; the other bit is 0.
  - resp_result and resp_flags come from the result registers and stay stable while waiting.
  - When resp_ready[gnt]=1: set last=gnt, go to IDLE.
  - resp_ready on the non-granted bit is ignored.
- Timing:
  - Latency: request accepted at edge N; resp_valid is high from cycle N+2.
  - Max throughput: one op per 3 cycles. No request is accepted while in EXEC or RESP.
- Fairness: with both requesters valid continuously, grants alternate 0,1,0,1,...
- Requesters must hold req_valid and their operands until ready. A requester that drops valid before grant simply loses that cycle.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded, no response is issued, and the block returns to the reset state.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined:
  - Adds output ports grant_cnt0 and grant_cnt1, 16 bits each.
  - Each counts accepted requests for its requester and saturates at 16'hFFFF.
  - Both clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_arb_pkg holds:
  - state enum {IDLE, EXEC, RESP};
  - ALUControl constants ALU_ADD=00, ALU_SUB=01, ALU_AND=10, ALU_ORR=11;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module rr_arb2: combinational 2-way round-robin pick.
  - Inputs: req[1:0], last.
  - Outputs: gnt_onehot[1:0], gnt_idx.

Test Plan:
1. Reset, then req0 add 5+3 (req_valid=01) -> req_ready=01 for one cycle; 2 cycles later resp_valid=01, resp_result=0x00000008, resp_flags=0000.
2. req1 sub 3-5 -> resp_valid=10, resp_result=0xFFFFFFFE, resp_flags=1000.
3. req0 sub 5-5 -> resp_result=0, flags=0110. Then req1 orr 0xF0|0x0F -> 0x000000FF, flags=0000.
4. After reset, both valid every cycle, each doing add 1+1 -> grant order 0,1,0,1; each resp_valid pulse lands on the correct bit; no starvation over 8 ops.
5. resp_ready held low 4 cycles in RESP -> resp_valid, resp_result and resp_flags unchanged; req_ready stays 00 even with both req_valid set. Release -> accepted next IDLE.
6. reset=0 asserted during EXEC -> next cycle resp_valid=00, req_ready follows IDLE rules, next grant goes to requester 0. With ALU_ARB_PERF_EN defined, counters read 0 after reset and increment once per accept.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the ALU arbiter slice:
//   - state_t       : arbiter sequencing states (IDLE, EXEC, RESP)
//   - ALU_*         : ALUControl encodings understood by the shared alu
//   - FLAG_*        : bit positions inside the 4-bit {N,Z,C,V} flag vector
//   - idx_to_onehot : maps a requester index to its one-hot bit pair
// ---------------------------------------------------------------------------
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
// Ports:
//   req        [1:0] in  : request bits
//   last             in  : index of the requester served most recently
//   gnt_onehot [1:0] out : one-hot grant, all-zero when nothing requests
//   gnt_idx          out : index of the picked requester (0 when idle)
// ---------------------------------------------------------------------------
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt_onehot,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      // Contention: the requester that was not served last goes first.
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

  // Masking with req keeps the one-hot vector clear when nobody asks.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_onehot
      assign gnt_onehot[gi] = req[gi] & (gnt_idx == 1'(gi));
    end
  endgenerate

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational alu between two requesters. Each
// requester has a valid/ready request channel and a valid/ready response
// channel. A three-state FSM (IDLE -> EXEC -> RESP) accepts one operation,
// lets the alu evaluate the latched operands for a cycle, then holds the
// result until the granted requester consumes it. Ties are broken
// round-robin; after reset requester 0 wins first.
//
// Ports:
//   clk, reset               : clock; synchronous active-low reset
//   req_valid/req_ready [1:0]: request handshake, bit i = requester i
//   req{0,1}_srca/srcb/ctrl  : per-requester operands and ALUControl
//   resp_valid/resp_ready    : response handshake, bit i = requester i
//   resp_result, resp_flags  : shared result bus and {N,Z,C,V}
//   alu_srca/srcb/ctrl       : operands to the external alu
//   alu_result, alu_flags    : outputs of the external alu
//   grant_cnt0/1 [15:0]      : saturating accept counters, present only
//                              when ALU_ARB_PERF_EN is defined
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_srca,
  input  logic [WIDTH-1:0] req0_srcb,
  input  logic [1:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req1_srca,
  input  logic [WIDTH-1:0] req1_srcb,
  input  logic [1:0]       req1_ctrl,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic [3:0]       resp_flags,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] opa_reg, opb_reg, res_reg;
  logic [1:0]       opc_reg;
  logic [3:0]       flags_reg;
  logic             gnt_reg, last_reg;

  logic [1:0]       pick_onehot;
  logic             pick_idx;
  logic             accept, resp_done;

  rr_arb2 u_rr (
    .req        (req_valid),
    .last       (last_reg),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx)
  );

  always_comb begin
    state_next = state_reg;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    accept     = 1'b0;
    resp_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        // pick_onehot is already qualified by req_valid, so a nonzero
        // ready is exactly the handshake.
        req_ready = pick_onehot;
        if (|pick_onehot) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        resp_valid = idx_to_onehot(gnt_reg);
        // Only the granted requester's ready matters here.
        if (resp_ready[gnt_reg]) begin
          resp_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      opa_reg   <= '0;
      opb_reg   <= '0;
      opc_reg   <= 2'b00;
      res_reg   <= '0;
      flags_reg <= 4'b0000;
      gnt_reg   <= 1'b0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        opa_reg <= pick_idx ? req1_srca : req0_srca;
        opb_reg <= pick_idx ? req1_srcb : req0_srcb;
        opc_reg <= pick_idx ? req1_ctrl : req0_ctrl;
        gnt_reg <= pick_idx;
      end
      // The alu has had a full cycle on the latched operands by now.
      if (state_reg == EXEC) begin
        res_reg   <= alu_result;
        flags_reg <= alu_flags;
      end
      if (resp_done) begin
        last_reg <= gnt_reg;
      end
    end
  end

  assign alu_srca    = opa_reg;
  assign alu_srcb    = opb_reg;
  assign alu_ctrl    = opc_reg;
  assign resp_result = res_reg;
  assign resp_flags  = flags_reg;

`ifdef ALU_ARB_PERF_EN
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [15:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt_reg <= 16'd0;
        end else if (accept && (pick_idx == 1'(gi)) && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
    end
  endgenerate

  assign grant_cnt0 = g_cnt[0].cnt_reg;
  assign grant_cnt1 = g_cnt[1].cnt_reg;
`endif

endmodule
